// File: rtl/ofdm_pkg.sv
// rtl/ofdm_pkg.sv - shared OFDM receive types, sample packing and default symbol geometry
package ofdm_pkg;

    typedef enum logic [1:0] {
        S_CP  = 2'd0,
        S_SYM = 2'd1,
        S_PAD = 2'd2
    } cp_state_t;

    localparam int SAMPLE_W = 32;
    localparam int I_MSB    = 31;
    localparam int I_LSB    = 16;
    localparam int Q_MSB    = 15;
    localparam int Q_LSB    = 0;

    localparam int TUSER_W        = 2;
    localparam int TUSER_PAD_BIT  = 0;
    localparam int TUSER_LAST_BIT = 1;

    localparam int DEFAULT_FFT_SIZE = 1024;
    localparam int DEFAULT_CP_SIZE  = 128;

endpackage

// File: rtl/cp_remover_if.sv
// rtl/cp_remover_if.sv - sample input stream and CP-stripped output stream of the CP remover
interface cp_remover_if;
    import ofdm_pkg::*;

    logic [SAMPLE_W-1:0] i_tdata;
    logic                i_tlast;
    logic                i_tvalid;
    logic                i_tready;

    logic [SAMPLE_W-1:0] o_tdata;
    logic                o_tlast;
    logic [TUSER_W-1:0]  o_tuser;
    logic                o_tvalid;
    logic                o_tready;

    modport slave (
        input  i_tdata, i_tlast, i_tvalid, o_tready,
        output i_tready, o_tdata, o_tlast, o_tuser, o_tvalid
    );

    modport master (
        output i_tdata, i_tlast, i_tvalid, o_tready,
        input  i_tready, o_tdata, o_tlast, o_tuser, o_tvalid
    );

endinterface

// File: rtl/cp_remover.sv
// rtl/cp_remover.sv - strips the cyclic prefix from each OFDM symbol and zero-pads truncated symbols
module cp_remover
    import ofdm_pkg::*;
#(
    parameter int FFT_SIZE = DEFAULT_FFT_SIZE,
    parameter int CP_SIZE  = DEFAULT_CP_SIZE
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    cp_remover_if.slave   bus,
    output logic [15:0]   sym_count,
    output logic          trunc_pulse
);

    localparam int SW = $clog2(FFT_SIZE);
    localparam int CW = (CP_SIZE > 1) ? $clog2(CP_SIZE) : 1;
    localparam logic [SW-1:0] SYM_LAST = SW'(FFT_SIZE - 1);
    localparam logic [CW-1:0] CP_LAST  = CW'(CP_SIZE - 1);

    cp_state_t           state_q, state_d;
    logic [CW-1:0]       cp_cnt_q, cp_cnt_d;
    logic [SW-1:0]       sym_idx_q, sym_idx_d;
    logic [15:0]         sym_count_q, sym_count_d;
    logic                trunc_q, trunc_d;
    logic [SAMPLE_W-1:0] o_tdata_q, o_tdata_d;
    logic                o_tlast_q, o_tlast_d;
    logic [TUSER_W-1:0]  o_tuser_q, o_tuser_d;
    logic                o_tvalid_q, o_tvalid_d;
    logic                i_tready_c;
    logic                out_free;
    logic                sym_last;

    assign out_free = ~o_tvalid_q | bus.o_tready;
    assign sym_last = (sym_idx_q == SYM_LAST);

    always_comb begin
        state_d     = state_q;
        cp_cnt_d    = cp_cnt_q;
        sym_idx_d   = sym_idx_q;
        sym_count_d = sym_count_q;
        trunc_d     = 1'b0;
        o_tdata_d   = o_tdata_q;
        o_tlast_d   = o_tlast_q;
        o_tuser_d   = o_tuser_q;
        o_tvalid_d  = o_tvalid_q;
        i_tready_c  = 1'b0;

        // Packet count restarts once the packet's closing sample leaves the block
        if (o_tvalid_q && bus.o_tready) begin
            o_tvalid_d = 1'b0;
            if (o_tlast_q && o_tuser_q[TUSER_LAST_BIT]) begin
                sym_count_d = '0;
            end
        end

        case (state_q)
            S_CP: begin
                i_tready_c = 1'b1;
                if (bus.i_tvalid) begin
                    if (bus.i_tlast) begin
                        cp_cnt_d    = '0;
                        sym_count_d = '0;
                    end else if (cp_cnt_q == CP_LAST) begin
                        cp_cnt_d  = '0;
                        sym_idx_d = '0;
                        state_d   = S_SYM;
                    end else begin
                        cp_cnt_d = cp_cnt_q + 1'b1;
                    end
                end
            end
            S_SYM: begin
                i_tready_c = out_free;
                if (bus.i_tvalid && out_free) begin
                    o_tvalid_d = 1'b1;
                    o_tdata_d  = bus.i_tdata;
                    o_tlast_d  = sym_last;
                    o_tuser_d  = {bus.i_tlast & sym_last, 1'b0};
                    sym_idx_d  = sym_idx_q + 1'b1;
                    if (sym_last) begin
                        state_d     = S_CP;
                        cp_cnt_d    = '0;
                        sym_count_d = (sym_count_q == 16'hFFFF) ? sym_count_q : sym_count_q + 16'd1;
                    end else if (bus.i_tlast) begin
                        trunc_d = 1'b1;
                        state_d = S_PAD;
                    end
                end
            end
            S_PAD: begin
                if (out_free) begin
                    o_tvalid_d = 1'b1;
                    o_tdata_d  = '0;
                    o_tlast_d  = sym_last;
                    o_tuser_d  = {sym_last, 1'b1};
                    sym_idx_d  = sym_idx_q + 1'b1;
                    if (sym_last) begin
                        state_d  = S_CP;
                        cp_cnt_d = '0;
                    end
                end
            end
            default: begin
                state_d = S_CP;
            end
        endcase

        if (clear) begin
            state_d     = S_CP;
            cp_cnt_d    = '0;
            sym_idx_d   = '0;
            sym_count_d = '0;
            trunc_d     = 1'b0;
            o_tdata_d   = '0;
            o_tlast_d   = 1'b0;
            o_tuser_d   = '0;
            o_tvalid_d  = 1'b0;
            i_tready_c  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_CP;
            cp_cnt_q    <= '0;
            sym_idx_q   <= '0;
            sym_count_q <= '0;
            trunc_q     <= 1'b0;
            o_tdata_q   <= '0;
            o_tlast_q   <= 1'b0;
            o_tuser_q   <= '0;
            o_tvalid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cp_cnt_q    <= cp_cnt_d;
            sym_idx_q   <= sym_idx_d;
            sym_count_q <= sym_count_d;
            trunc_q     <= trunc_d;
            o_tdata_q   <= o_tdata_d;
            o_tlast_q   <= o_tlast_d;
            o_tuser_q   <= o_tuser_d;
            o_tvalid_q  <= o_tvalid_d;
        end
    end

    assign bus.i_tready = i_tready_c & reset;
    assign bus.o_tdata  = o_tdata_q;
    assign bus.o_tlast  = o_tlast_q;
    assign bus.o_tuser  = o_tuser_q;
    assign bus.o_tvalid = o_tvalid_q;
    assign sym_count    = sym_count_q;
    assign trunc_pulse  = trunc_q;

endmodule

// File: tb/tb_cp_remover.sv
// tb/tb_cp_remover.sv - randomized self-checking bench for cp_remover against a packet-level model
module tb_cp_remover;
    localparam int FFT = 16;
    localparam int CP  = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic [15:0] sym_count;
    logic        trunc_pulse;

    cp_remover_if ifc ();

    cp_remover #(.FFT_SIZE(FFT), .CP_SIZE(CP)) dut (
        .clk         (clk),
        .reset       (rst_n),
        .clear       (clear),
        .bus         (ifc.slave),
        .sym_count   (sym_count),
        .trunc_pulse (trunc_pulse)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int          mode     = 0;
    logic [31:0] pkt_q[$];
    logic [34:0] exp_q[$];
    logic [34:0] got_q[$];
    int          stall_err = 0;
    int          trunc_cnt = 0;
    int          tlast_cnt = 0;
    int          sym2_cnt  = 0;

    // Output monitor: picks o_tready for the coming edge, then records what that edge consumes
    initial begin : monitor
        logic        tog;
        logic        prev_stalled;
        logic [34:0] prev;
        logic [34:0] cur;
        tog = 1'b0;
        prev_stalled = 1'b0;
        prev = '0;
        ifc.o_tready = 1'b0;
        forever begin
            @(negedge clk);
            case (mode)
                0: ifc.o_tready = 1'b1;
                1: begin tog = ~tog; ifc.o_tready = tog; end
                default: ifc.o_tready = ($urandom_range(0, 2) != 0);
            endcase
            #2;
            cur = {ifc.o_tdata, ifc.o_tlast, ifc.o_tuser};
            if (rst_n && !clear) begin
                if (prev_stalled && cur !== prev) stall_err++;
                if (ifc.o_tvalid && ifc.o_tready) begin
                    got_q.push_back(cur);
                    if (ifc.o_tlast) tlast_cnt++;
                end
                if (trunc_pulse) trunc_cnt++;
                if (sym_count == 16'd2) sym2_cnt++;
                prev_stalled = ifc.o_tvalid && !ifc.o_tready;
                prev = cur;
            end else begin
                prev_stalled = 1'b0;
            end
        end
    end

    function automatic void model_packet();
        int n;
        int pos;
        int idx;
        bit fin;
        n = pkt_q.size();
        for (int p = 0; p < n; p++) begin
            pos = p % (CP + FFT);
            if (pos >= CP) begin
                idx = pos - CP;
                fin = (p == n - 1);
                exp_q.push_back({pkt_q[p], idx == FFT - 1, fin && (idx == FFT - 1), 1'b0});
                if (fin && idx < FFT - 1)
                    for (int k = idx + 1; k < FFT; k++)
                        exp_q.push_back({32'd0, k == FFT - 1, k == FFT - 1, 1'b1});
            end
        end
    endfunction

    task automatic send_packet(input int n, input bit ramp, input bit gaps, input bit with_last);
        bit acc;
        int waitc;
        logic [31:0] d;
        pkt_q.delete();
        for (int p = 0; p < n; p++) begin
            d = ramp ? 32'(p) : $urandom;
            pkt_q.push_back(d);
            if (gaps && $urandom_range(0, 3) == 0) begin
                @(negedge clk); #1 ifc.i_tvalid = 1'b0;
                @(posedge clk);
            end
            acc = 1'b0;
            waitc = 0;
            while (!acc) begin
                @(negedge clk); #1;
                ifc.i_tvalid = 1'b1;
                ifc.i_tdata  = d;
                ifc.i_tlast  = with_last && (p == n - 1);
                #2 acc = ifc.i_tready;
                @(posedge clk);
                waitc++;
                if (!acc && waitc > 200) begin
                    checks++; failures++;
                    $display("FAIL input_accept_timeout sample=%0d got=stuck exp=accepted", p);
                    acc = 1'b1;
                end
            end
        end
        @(negedge clk); #1;
        ifc.i_tvalid = 1'b0;
        ifc.i_tlast  = 1'b0;
    endtask

    task automatic wait_drain(input int base);
        int c;
        c = 0;
        while ((got_q.size() - base) < exp_q.size() && c < 1000) begin
            @(negedge clk);
            c++;
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear = 1'b0;
        ifc.i_tvalid = 1'b1;
        ifc.i_tdata  = 32'hDEADBEEF;
        ifc.i_tlast  = 1'b0;
        repeat (3) @(negedge clk);
        #3;
        checks++; if (ifc.i_tready !== 1'b0) begin failures++; $display("FAIL reset_i_tready got=%b exp=0", ifc.i_tready); end
        checks++; if (ifc.o_tvalid !== 1'b0) begin failures++; $display("FAIL reset_o_tvalid got=%b exp=0", ifc.o_tvalid); end
        checks++; if (ifc.o_tdata !== 32'd0) begin failures++; $display("FAIL reset_o_tdata got=%h exp=0", ifc.o_tdata); end
        checks++; if (ifc.o_tlast !== 1'b0) begin failures++; $display("FAIL reset_o_tlast got=%b exp=0", ifc.o_tlast); end
        checks++; if (ifc.o_tuser !== 2'b00) begin failures++; $display("FAIL reset_o_tuser got=%b exp=0", ifc.o_tuser); end
        checks++; if (sym_count !== 16'd0) begin failures++; $display("FAIL reset_sym_count got=%0d exp=0", sym_count); end
        checks++; if (trunc_pulse !== 1'b0) begin failures++; $display("FAIL reset_trunc got=%b exp=0", trunc_pulse); end
        ifc.i_tvalid = 1'b0;
        @(negedge clk); #1 rst_n = 1'b1;
        #2;
        checks++; if (ifc.i_tready !== 1'b1) begin failures++; $display("FAIL cp_i_tready got=%b exp=1", ifc.i_tready); end
    endtask

    task automatic test_ramp(input int m);
        int base, s2, se, tc;
        mode = m;
        exp_q.delete();
        repeat (2) @(negedge clk);
        base = got_q.size(); s2 = sym2_cnt; se = stall_err; tc = trunc_cnt;
        send_packet(40, 1'b1, 1'b0, 1'b1);
        model_packet();
        wait_drain(base);
        checks++; if (got_q.size() - base != exp_q.size()) begin failures++; $display("FAIL ramp_len mode=%0d got=%0d exp=%0d", m, got_q.size() - base, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
            checks++;
            if (got_q[base + i] !== exp_q[i]) begin failures++; $display("FAIL ramp_sample mode=%0d idx=%0d got=%h exp=%h", m, i, got_q[base + i], exp_q[i]); end
        end
        checks++; if (sym2_cnt == s2) begin failures++; $display("FAIL ramp_sym_count_peak mode=%0d got=never2 exp=reaches2", m); end
        checks++; if (sym_count !== 16'd0) begin failures++; $display("FAIL ramp_sym_count_end mode=%0d got=%0d exp=0", m, sym_count); end
        checks++; if (stall_err != se) begin failures++; $display("FAIL ramp_stall_hold mode=%0d got=%0d exp=0", m, stall_err - se); end
        checks++; if (trunc_cnt != tc) begin failures++; $display("FAIL ramp_trunc mode=%0d got=%0d exp=0", m, trunc_cnt - tc); end
    endtask

    task automatic test_trunc();
        int base, tc;
        mode = 0;
        exp_q.delete();
        base = got_q.size(); tc = trunc_cnt;
        send_packet(10, 1'b1, 1'b0, 1'b1);
        model_packet();
        wait_drain(base);
        checks++; if (got_q.size() - base != 16) begin failures++; $display("FAIL trunc_len got=%0d exp=16", got_q.size() - base); end
        for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
            checks++;
            if (got_q[base + i] !== exp_q[i]) begin failures++; $display("FAIL trunc_sample idx=%0d got=%h exp=%h", i, got_q[base + i], exp_q[i]); end
        end
        checks++; if (trunc_cnt - tc != 1) begin failures++; $display("FAIL trunc_pulse_count got=%0d exp=1", trunc_cnt - tc); end
        checks++; if (sym_count !== 16'd0) begin failures++; $display("FAIL trunc_sym_count got=%0d exp=0", sym_count); end
    endtask

    task automatic test_cp_tlast();
        int base;
        mode = 0;
        base = got_q.size();
        send_packet(3, 1'b1, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        checks++; if (got_q.size() != base) begin failures++; $display("FAIL cp_tlast_output got=%0d exp=0", got_q.size() - base); end
        checks++; if (sym_count !== 16'd0) begin failures++; $display("FAIL cp_tlast_sym_count got=%0d exp=0", sym_count); end
        test_ramp(0);
    endtask

    task automatic test_reset_mid();
        mode = 0;
        send_packet(11, 1'b1, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        checks++; if (ifc.o_tvalid !== 1'b0) begin failures++; $display("FAIL reset_mid_o_tvalid got=%b exp=0", ifc.o_tvalid); end
        checks++; if (ifc.i_tready !== 1'b0) begin failures++; $display("FAIL reset_mid_i_tready got=%b exp=0", ifc.i_tready); end
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        test_ramp(0);
    endtask

    task automatic test_clear_pad();
        int base, tl;
        mode = 0;
        send_packet(10, 1'b1, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        #1 clear = 1'b1;
        @(negedge clk); #1 clear = 1'b0;
        base = got_q.size(); tl = tlast_cnt;
        repeat (30) @(negedge clk);
        checks++; if (got_q.size() != base) begin failures++; $display("FAIL clear_pad_output got=%0d exp=0", got_q.size() - base); end
        checks++; if (tlast_cnt != tl) begin failures++; $display("FAIL clear_pad_tlast got=%0d exp=0", tlast_cnt - tl); end
        checks++; if (sym_count !== 16'd0) begin failures++; $display("FAIL clear_pad_sym_count got=%0d exp=0", sym_count); end
        test_ramp(1);
    endtask

    task automatic test_random();
        int base, se, n;
        mode = 2;
        exp_q.delete();
        base = got_q.size(); se = stall_err;
        for (int k = 0; k < 8; k++) begin
            n = $urandom_range(1, 60);
            send_packet(n, 1'b0, 1'b1, 1'b1);
            model_packet();
        end
        wait_drain(base);
        checks++; if (got_q.size() - base != exp_q.size()) begin failures++; $display("FAIL random_len got=%0d exp=%0d", got_q.size() - base, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
            checks++;
            if (got_q[base + i] !== exp_q[i]) begin failures++; $display("FAIL random_sample idx=%0d got=%h exp=%h", i, got_q[base + i], exp_q[i]); end
        end
        checks++; if (stall_err != se) begin failures++; $display("FAIL random_stall_hold got=%0d exp=0", stall_err - se); end
    endtask

    initial begin
        ifc.i_tvalid = 1'b0;
        ifc.i_tdata  = '0;
        ifc.i_tlast  = 1'b0;
        test_reset();
        test_ramp(0);
        test_ramp(1);
        test_trunc();
        test_cp_tlast();
        test_reset_mid();
        test_clear_pad();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
